airi5c_dmem_req_buffer: RTL



---
 rtl/airi5c_dmem_req_buffer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/airi5c_dmem_req_buffer.sv
// Data-memory request stage: latches load/store fields, holds them across bus wait
// states, builds byte enables and lane-replicated store data, and extends load data.
module airi5c_dmem_req_buffer #(
    parameter int XLEN      = 32,
    parameter bit BYPASS    = 1'b1,
    parameter bit HOLD_ADDR = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [XLEN-1:0]   alu_out_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic              stall_o,
    output logic              misaligned_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [XLEN/8-1:0] dmem_be_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    input  logic              dmem_ready_i,
    input  logic              dmem_err_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic              rsp_valid_o,
    output logic [XLEN-1:0]   rsp_rdata_o,
    output logic              rsp_err_o
);
    // state | meaning
    // IDLE  | no transfer pending; may accept (and in bypass mode issue) a request
    // WAIT  | transfer issued from latched fields, waiting for dmem_ready_i

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int SW = $clog2(XLEN);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            we_q;
    logic            uns_q;
    logic [1:0]      size_q;

    logic            mis;
    logic            accept;
    logic [OW-1:0]   in_off;

    logic [XLEN-1:0] act_addr;
    logic [XLEN-1:0] act_wdata;
    logic            act_we;
    logic            act_uns;
    logic [1:0]      act_size;
    logic [OW-1:0]   act_off;

    logic [NB-1:0]   be_full;
    logic [XLEN-1:0] wd_rep;
    logic [XLEN-1:0] rd_shift;
    logic [XLEN-1:0] ext;
    logic [SW-1:0]   msb;
    logic            fill;

    always_comb begin
        in_off = alu_out_i[OW-1:0];
        mis    = 1'b0;
        case (req_size_i)
            2'b00:   mis = 1'b0;
            2'b01:   mis = alu_out_i[0];
            2'b10:   mis = |alu_out_i[1:0];
            default: mis = (XLEN == 32) || (|in_off);
        endcase
    end

    // Reset gates acceptance so the bus request drops the instant reset asserts.
    assign accept       = rst_ni && (state_q == IDLE) && req_valid_i && !mis;
    assign misaligned_o = rst_ni && (state_q == IDLE) && req_valid_i && mis;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= alu_out_i;
                wdata_q <= wdata_i;
                we_q    <= req_we_i;
                uns_q   <= req_unsigned_i;
                size_q  <= req_size_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (BYPASS && dmem_ready_i) ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (dmem_ready_i) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // In WAIT the latched fields drive the bus; otherwise the live inputs do (bypass issue).
    always_comb begin
        if (state_q == WAIT) begin
            act_addr  = addr_q;
            act_wdata = wdata_q;
            act_we    = we_q;
            act_uns   = uns_q;
            act_size  = size_q;
        end else begin
            act_addr  = alu_out_i;
            act_wdata = wdata_i;
            act_we    = req_we_i;
            act_uns   = req_unsigned_i;
            act_size  = req_size_i;
        end
        act_off = act_addr[OW-1:0];
    end

    always_comb begin
        be_full = '0;
        wd_rep  = '0;
        case (act_size)
            2'b00: begin
                be_full = NB'(1) << act_off;
                wd_rep  = {NB{act_wdata[7:0]}};
            end
            2'b01: begin
                be_full = NB'(3) << act_off;
                wd_rep  = {(NB/2){act_wdata[15:0]}};
            end
            2'b10: begin
                be_full = NB'(4'hF) << act_off;
                wd_rep  = {(NB/4){act_wdata[31:0]}};
            end
            default: begin
                be_full = '1;
                wd_rep  = act_wdata;
            end
        endcase
    end

    assign dmem_req_o   = (state_q == WAIT) || (BYPASS && accept);
    assign dmem_we_o    = dmem_req_o & act_we;
    assign dmem_addr_o  = dmem_req_o ? act_addr : (HOLD_ADDR ? addr_q : '0);
    assign dmem_be_o    = dmem_req_o ? be_full : '0;
    assign dmem_wdata_o = dmem_req_o ? wd_rep : '0;

    assign stall_o      = (dmem_req_o & ~dmem_ready_i) | (!BYPASS && accept);
    assign rsp_valid_o  = dmem_req_o & dmem_ready_i;
    assign rsp_err_o    = rsp_valid_o & dmem_err_i;

    always_comb begin
        rd_shift = dmem_rdata_i >> {act_off, 3'b000};
        case (act_size)
            2'b00:   msb = SW'(7);
            2'b01:   msb = SW'(15);
            2'b10:   msb = SW'(31);
            default: msb = SW'(XLEN - 1);
        endcase
        fill = ~act_uns & rd_shift[msb];
        ext  = '0;
        for (int i = 0; i < XLEN; i++) begin
            ext[i] = (SW'(i) > msb) ? fill : rd_shift[i];
        end
    end

    assign rsp_rdata_o = (rsp_valid_o & ~act_we) ? ext : '0;

endmodule
